// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_feed parallel-to-serial feeder.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  localparam int GW = 4;

  // Bit-counter width; it must hold W-1, and W >= 2 keeps this at least 1.
  function automatic int cw_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_feed_if.sv
// Word handshake in, serial stream and status out for the ser_feed feeder.
interface ser_feed_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         dv;
  logic         rdy;
  logic         a;
  logic         fr;
  logic         busy;
  logic         done;

  modport master (
    output din, dv,
    input  rdy, a, fr, busy, done
  );

  modport slave (
    input  din, dv,
    output rdy, a, fr, busy, done
  );
endinterface

// File: rtl/ser_dcnt.sv
// Loadable down-counter that saturates at zero and flags it.
module ser_dcnt #(
  parameter int N = 4
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ser_feed.sv
// Parallel-to-serial feeder: accepts a W-bit word on dv/rdy and shifts it out
// on `a` one bit per clock, optionally followed by GAP forced idle cycles.
module ser_feed
  import ser_pkg::*;
#(
  parameter int W         = 8,
  parameter int GAP       = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic          ck,
  input  logic          rst,
  ser_feed_if.slave     bus
);

  localparam int            CW       = cw_of(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e         state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic           a_q, a_d;
  logic           fr_q, fr_d;
  logic           done_q, done_d;

  logic           cnt_zero, gcnt_zero;
  logic           cnt_load, cnt_dec;
  logic           gcnt_load, gcnt_dec;
  logic           rdy, accept;
  logic           first_bit, next_bit;
  logic [W-1:0]   din_rest, sh_next;

  ser_dcnt #(.N(CW)) u_bcnt (
    .ck     (ck),
    .rst    (rst),
    .load_i (cnt_load),
    .val_i  (CNT_LOAD),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  ser_dcnt #(.N(GW)) u_gcnt (
    .ck     (ck),
    .rst    (rst),
    .load_i (gcnt_load),
    .val_i  (GAP_LOAD),
    .dec_i  (gcnt_dec),
    .zero_o (gcnt_zero)
  );

  // With no gap, the last-bit cycle can take the next word for seamless streaming.
  assign rdy    = (state_q == ST_IDLE) ||
                  ((state_q == ST_SHIFT) && cnt_zero && (GAP == 0));
  assign accept = bus.dv && rdy;

  always_comb begin
    if (LSB_FIRST != 0) begin
      first_bit = bus.din[0];
      din_rest  = bus.din >> 1;
      next_bit  = sh_q[0];
      sh_next   = sh_q >> 1;
    end else begin
      first_bit = bus.din[W-1];
      din_rest  = bus.din << 1;
      next_bit  = sh_q[W-1];
      sh_next   = sh_q << 1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      a_q     <= 1'b0;
      fr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      a_q     <= a_d;
      fr_q    <= fr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_zero && !accept) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gcnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d       = 1'b0;
    fr_d      = 1'b0;
    sh_d      = sh_q;
    cnt_load  = accept;
    cnt_dec   = 1'b0;
    if (accept) begin
      a_d  = first_bit;
      fr_d = 1'b1;
      sh_d = din_rest;
    end else if ((state_q == ST_SHIFT) && !cnt_zero) begin
      a_d     = next_bit;
      fr_d    = 1'b1;
      sh_d    = sh_next;
      cnt_dec = 1'b1;
    end
    done_d    = (state_q == ST_SHIFT) && cnt_zero;
    gcnt_load = (state_q == ST_SHIFT) && cnt_zero && !accept && (GAP > 0);
    gcnt_dec  = (state_q == ST_GAP);
  end

  assign bus.rdy  = rdy;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.a    = a_q;
  assign bus.fr   = fr_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_ser_feed.sv
// Bench for ser_feed: two instances (GAP=0 MSB-first, GAP=2 LSB-first) checked
// every cycle against a timing model built from accept times and word contents.
module tb_ser_feed;

  localparam int W = 8;
  localparam int GAP_P [2] = '{0, 2};
  localparam int LSB_P [2] = '{0, 1};

  logic ck;
  logic rst;
  logic         dv_t  [2];
  logic [W-1:0] din_t [2];
  logic [4:0]   obs   [2];

  ser_feed_if #(.W(W)) ifa ();
  ser_feed_if #(.W(W)) ifb ();

  assign ifa.dv  = dv_t[0];
  assign ifa.din = din_t[0];
  assign ifb.dv  = dv_t[1];
  assign ifb.din = din_t[1];
  assign obs[0]  = {ifa.a, ifa.fr, ifa.done, ifa.busy, ifa.rdy};
  assign obs[1]  = {ifb.a, ifb.fr, ifb.done, ifb.busy, ifb.rdy};

  ser_feed #(.W(W), .GAP(0), .LSB_FIRST(0)) dut_a (.ck(ck), .rst(rst), .bus(ifa.slave));
  ser_feed #(.W(W), .GAP(2), .LSB_FIRST(1)) dut_b (.ck(ck), .rst(rst), .bus(ifb.slave));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference model: remembers when each instance last accepted a word and what
  // it was; every expected output is arithmetic on the cycle offset from that.
  int           edge_n     = 0;
  int           acc_k  [2] = '{-1000, -1000};
  int           prev_k [2] = '{-1000, -1000};
  logic [W-1:0] acc_w  [2] = '{8'h00, 8'h00};

  function automatic logic [4:0] expect_out(input int i);
    int   off;
    logic ea, efr, edn, ebz, erd;
    off = edge_n - acc_k[i];
    efr = (off >= 0) && (off < W);
    ea  = 1'b0;
    if (efr) ea = (LSB_P[i] != 0) ? acc_w[i][off] : acc_w[i][W-1-off];
    edn = (off == W) || ((edge_n - prev_k[i]) == W);
    ebz = (off >= 0) && (off < W + GAP_P[i]);
    erd = !ebz || ((GAP_P[i] == 0) && (off == W - 1));
    return {ea, efr, edn, ebz, erd};
  endfunction

  function automatic logic model_rdy(input int i);
    logic [4:0] e;
    e = expect_out(i);
    return e[0];
  endfunction

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        acc_k[i]  <= -1000;
        prev_k[i] <= -1000;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < 2; i++) begin
        if (dv_t[i] && model_rdy(i)) begin
          prev_k[i] <= acc_k[i];
          acc_k[i]  <= edge_n + 1;
          acc_w[i]  <= din_t[i];
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cap_a, cap_b;
  int          fr_a, fr_b, ones_a, pulses_a;
  int          done_q[$];
  int          rise_q[$];
  logic        frb_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic clear_caps();
    cap_a = '0; cap_b = '0; fr_a = 0; fr_b = 0;
    done_q.delete(); rise_q.delete();
  endtask

  // One cycle: sample at negedge, compare both instances, feed the observers
  // (including the m2 ones-counter that listens to instance A).
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ck);
      if (!rst) begin
        check("cycle_a", obs[0], expect_out(0));
        check("cycle_b", obs[1], expect_out(1));
        if (ifa.fr) begin cap_a = {cap_a[30:0], ifa.a}; fr_a++; end
        if (ifb.fr) begin cap_b = {cap_b[30:0], ifb.a}; fr_b++; end
        if (ifa.done) done_q.push_back(edge_n);
        if (ifb.fr && !frb_prev) rise_q.push_back(edge_n);
        frb_prev = ifb.fr;
        if (ifa.a) begin
          ones_a++;
          if ((ones_a % 4) == 0) pulses_a++;
        end
      end
    end
  endtask

  task automatic send(input int sel, input logic [7:0] w);
    logic got;
    got = 1'b0;
    dv_t[sel]  = 1'b1;
    din_t[sel] = w;
    for (int k = 0; k < 40 && !got; k++) begin
      step(1);
      if (acc_k[sel] == edge_n) got = 1'b1;
    end
    check("accept_in_time", {31'd0, got}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    dv_t[0] = 1'b0; dv_t[1] = 1'b0;
    din_t[0] = '0;  din_t[1] = '0;
    ones_a = 0; pulses_a = 0;
    clear_caps();

    #2;
    check("reset_a", {27'd0, obs[0]}, 32'h01);
    check("reset_b", {27'd0, obs[1]}, 32'h01);
    #10 rst = 1'b0;
    step(3);

    // Single MSB-first word, one-cycle dv pulse.
    clear_caps();
    send(0, 8'hB0);
    dv_t[0] = 1'b0;
    step(12);
    check("word_b0_bits", cap_a[7:0], 8'hB0);
    check("word_b0_fr",   fr_a, 8);
    check("word_b0_done", done_q.size(), 1);

    // m2 chain: all-ones word gives two b pulses, 8'h03 adds two ones, none.
    ones_a = 0; pulses_a = 0;
    send(0, 8'hFF);
    dv_t[0] = 1'b0;
    step(10);
    check("m2_ff_pulses", pulses_a, 2);
    send(0, 8'h03);
    dv_t[0] = 1'b0;
    step(10);
    check("m2_03_pulses", pulses_a, 2);
    check("m2_03_count",  ones_a % 4, 2);

    // GAP=0 back-to-back with dv held.
    clear_caps();
    send(0, 8'hA5);
    send(0, 8'h3C);
    dv_t[0] = 1'b0;
    step(12);
    check("b2b_bits", cap_a[15:0], 16'hA53C);
    check("b2b_fr",   fr_a, 16);
    check("b2b_done_n", done_q.size(), 2);
    if (done_q.size() == 2) check("b2b_done_gap", done_q[1] - done_q[0], 8);

    // GAP=2, LSB-first instance, dv held across both words.
    clear_caps();
    send(1, 8'hC5);
    send(1, 8'h5A);
    dv_t[1] = 1'b0;
    step(14);
    check("gap_bits", cap_b[15:0], {rev8(8'hC5), rev8(8'h5A)});
    check("gap_fr",   fr_b, 16);
    check("gap_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) check("gap_spacing", rise_q[1] - rise_q[0], 11);

    // Asynchronous reset in the middle of a word, then a fresh word.
    send(0, 8'hFF);
    dv_t[0] = 1'b0;
    step(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_a", {27'd0, obs[0]}, 32'h01);
    check("midrst_b", {27'd0, obs[1]}, 32'h01);
    #29 rst = 1'b0;
    step(3);
    clear_caps();
    send(0, 8'h81);
    for (int k = 0; k < 2; k++) begin
      dv_t[0] = 1'b1; din_t[0] = 8'hFF;
      step(1);
      dv_t[0] = 1'b0;
      step(1);
    end
    step(8);
    check("after_rst_bits", cap_a[7:0], 8'h81);
    check("after_rst_fr",   fr_a, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
